// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: pipelined IN_W->OUT_W immediate extender (sign/zero/upper/branch) with a valid/ready skid buffer.
// Optional macro IMM_EXT_BRANCH_EN enables branch-offset mode 11; otherwise mode 11 yields zero with out_illegal set.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_illegal
);
    generate
        if (IN_W < 1 || OUT_W < IN_W + 2) begin : g_bad_params
            $error("imm_extend_pipe: need IN_W >= 1 and OUT_W >= IN_W + 2");
        end
    endgenerate

    logic             or_valid_q, or_valid_d, or_ill_q, or_ill_d;
    logic             sr_valid_q, sr_valid_d, sr_ill_q, sr_ill_d;
    logic [OUT_W-1:0] or_data_q, or_data_d, sr_data_q, sr_data_d;
    logic [OUT_W-1:0] sext, zext, upper, ext_data;
    logic             ext_ill, acc, or_free;

    assign sext  = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
    assign zext  = {{(OUT_W-IN_W){1'b0}}, in_imm};
    assign upper = {in_imm, {(OUT_W-IN_W){1'b0}}};

    always_comb begin
`ifdef IMM_EXT_BRANCH_EN
        ext_ill  = 1'b0;
        ext_data = in_mode == 2'b00 ? sext :
                   in_mode == 2'b01 ? zext :
                   in_mode == 2'b10 ? upper : {sext[OUT_W-3:0], 2'b00};
`else
        ext_ill  = in_mode == 2'b11;
        ext_data = in_mode == 2'b00 ? sext :
                   in_mode == 2'b01 ? zext :
                   in_mode == 2'b10 ? upper : '0;
`endif
    end

    // in_ready comes straight from the skid valid flop, so out_ready never reaches it combinationally
    assign acc     = in_valid && !sr_valid_q;
    assign or_free = !or_valid_q || out_ready;

    always_comb begin
        or_valid_d = or_free ? (sr_valid_q || acc) : or_valid_q;
        or_data_d  = or_free ? (sr_valid_q ? sr_data_q : (acc ? ext_data : or_data_q)) : or_data_q;
        or_ill_d   = or_free ? (sr_valid_q ? sr_ill_q : (acc ? ext_ill : or_ill_q)) : or_ill_q;
        sr_valid_d = !or_free && (sr_valid_q || acc);
        sr_data_d  = (!or_free && acc) ? ext_data : sr_data_q;
        sr_ill_d   = (!or_free && acc) ? ext_ill : sr_ill_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_valid_q <= 1'b0;
            or_data_q  <= '0;
            or_ill_q   <= 1'b0;
            sr_valid_q <= 1'b0;
            sr_data_q  <= '0;
            sr_ill_q   <= 1'b0;
        end else begin
            or_valid_q <= or_valid_d;
            or_data_q  <= or_data_d;
            or_ill_q   <= or_ill_d;
            sr_valid_q <= sr_valid_d;
            sr_data_q  <= sr_data_d;
            sr_ill_q   <= sr_ill_d;
        end
    end

    assign in_ready    = !sr_valid_q;
    assign out_valid   = or_valid_q;
    assign out_data    = or_data_q;
    assign out_illegal = or_ill_q;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed self-checking bench for imm_extend_pipe at default widths.
module tb_imm_extend_pipe;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [31:0] out_data;
    int          errors = 0;
    int          checks = 0;

    imm_extend_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode);
        in_valid = v;
        in_imm   = imm;
        in_mode  = mode;
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1;
        drive(1'b1, 16'h5555, 2'b00);
        step(); step();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_illegal", {31'b0, out_illegal}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        rst_n = 1'b1;
        drive(1'b1, 16'h8000, 2'b00); step();
        chk("sign_valid", {31'b0, out_valid}, 32'd1);
        chk("sign_data", out_data, 32'hFFFF8000);
        chk("sign_illegal", {31'b0, out_illegal}, 32'd0);
        drive(1'b1, 16'h8000, 2'b01); step();
        chk("zero_data", out_data, 32'h00008000);
        drive(1'b1, 16'h1234, 2'b10); step();
        chk("upper_data", out_data, 32'h12340000);
        drive(1'b1, 16'hFFFF, 2'b11); step();
`ifdef IMM_EXT_BRANCH_EN
        chk("branch_neg_data", out_data, 32'hFFFFFFFC);
        chk("branch_neg_illegal", {31'b0, out_illegal}, 32'd0);
`else
        chk("branch_neg_data", out_data, 32'd0);
        chk("branch_neg_illegal", {31'b0, out_illegal}, 32'd1);
`endif
        drive(1'b1, 16'h0004, 2'b11); step();
`ifdef IMM_EXT_BRANCH_EN
        chk("branch_pos_data", out_data, 32'h00000010);
        chk("branch_pos_illegal", {31'b0, out_illegal}, 32'd0);
`else
        chk("branch_pos_data", out_data, 32'd0);
        chk("branch_pos_illegal", {31'b0, out_illegal}, 32'd1);
`endif
        drive(1'b1, 16'h0004, 2'b00); step();
        chk("after_branch_data", out_data, 32'h00000004);
        chk("after_branch_illegal", {31'b0, out_illegal}, 32'd0);
        drive(1'b0, 16'h0000, 2'b00); step();
        chk("drain_out_valid", {31'b0, out_valid}, 32'd0);

        // backpressure: OR then SR fill, third offer must wait
        out_ready = 1'b0;
        drive(1'b1, 16'h0001, 2'b01); step();
        chk("bp1_in_ready", {31'b0, in_ready}, 32'd1);
        chk("bp1_data", out_data, 32'h00000001);
        drive(1'b1, 16'h0002, 2'b01); step();
        chk("bp2_in_ready", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 16'h0003, 2'b01); step();
        chk("bp_hold_data", out_data, 32'h00000001);
        chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1; step();
        chk("bp_rel_data2", out_data, 32'h00000002);
        chk("bp_rel_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("bp_rel_data3", out_data, 32'h00000003);
        chk("bp_rel_valid3", {31'b0, out_valid}, 32'd1);
        drive(1'b0, 16'h0000, 2'b00); step();
        chk("bp_empty", {31'b0, out_valid}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(16 + i), 2'b01); step();
            chk("stream_valid", {31'b0, out_valid}, 32'd1);
            chk("stream_data", out_data, 32'(16 + i));
            chk("stream_in_ready", {31'b0, in_ready}, 32'd1);
        end
        drive(1'b0, 16'h0000, 2'b00); step();
        chk("stream_end_valid", {31'b0, out_valid}, 32'd0);

        out_ready = 1'b0;
        drive(1'b1, 16'h000A, 2'b01); step();
        drive(1'b1, 16'h000B, 2'b01); step();
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0; step();
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_out_data", out_data, 32'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        drive(1'b1, 16'h000C, 2'b01); step();
        chk("postrst_data", out_data, 32'h0000000C);
        chk("postrst_valid", {31'b0, out_valid}, 32'd1);
        drive(1'b0, 16'h0000, 2'b00); step();
        chk("postrst_empty", {31'b0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
